// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared sizes, entry layout and register one-hot helper for the issue queue
package issue_queue_pkg;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BUS_W = 211;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    typedef struct packed {
        logic [BUS_W-1:0] bus;
        logic [4:0]       rj;
        logic [4:0]       rkd;
        logic [4:0]       dest;
        logic             gr_we;
    } iq_entry_t;
    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        return 32'd1 << r;
    endfunction
endpackage

// File: rtl/issue_queue_if.sv
// issue_queue_if: ID-side enqueue, issue-side handshake, writeback and control signals of the issue queue
interface issue_queue_if;
    import issue_queue_pkg::*;
    logic             ds_flush;
    logic             sb_clear;
    logic             ds_to_is_valid;
    logic [BUS_W-1:0] ds_to_is_bus;
    logic [4:0]       ds_rj;
    logic [4:0]       ds_rkd;
    logic [4:0]       ds_dest;
    logic             ds_gr_we;
    logic             IQ_allowin;
    logic             is_allowin;
    logic             iq_to_is_valid;
    logic [BUS_W-1:0] iq_to_is_bus;
    logic             wb_valid;
    logic [4:0]       wb_dest;
    logic [PTR_W:0]   iq_count;
    modport slave (
        input  ds_flush, sb_clear, ds_to_is_valid, ds_to_is_bus, ds_rj, ds_rkd, ds_dest, ds_gr_we,
        input  is_allowin, wb_valid, wb_dest,
        output IQ_allowin, iq_to_is_valid, iq_to_is_bus, iq_count
    );
    modport master (
        output ds_flush, sb_clear, ds_to_is_valid, ds_to_is_bus, ds_rj, ds_rkd, ds_dest, ds_gr_we,
        output is_allowin, wb_valid, wb_dest,
        input  IQ_allowin, iq_to_is_valid, iq_to_is_bus, iq_count
    );
endinterface

// File: rtl/issue_queue_scoreboard.sv
// iq_scoreboard: busy bit per architectural register, set on issue, cleared on writeback, with same-cycle writeback bypass on reads
module iq_scoreboard
    import issue_queue_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sb_clear_i,
    input  logic       set_en_i,
    input  logic [4:0] set_reg_i,
    input  logic       wb_valid_i,
    input  logic [4:0] wb_dest_i,
    input  logic [4:0] rd0_reg_i,
    input  logic [4:0] rd1_reg_i,
    output logic       rd0_busy_o,
    output logic       rd1_busy_o
);
    logic [31:0] busy_q, busy_d, busy_eff;
    // writeback releases its register this cycle; an issuing writer re-marks it and wins; r0 never busy
    always_comb begin
        busy_eff   = busy_q & ~(wb_valid_i ? reg_onehot(wb_dest_i) : 32'd0);
        busy_d     = sb_clear_i ? 32'd0 : (busy_eff | (set_en_i ? reg_onehot(set_reg_i) : 32'd0)) & ~32'd1;
        rd0_busy_o = busy_eff[rd0_reg_i];
        rd1_busy_o = busy_eff[rd1_reg_i];
    end
    // busy vector register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end
endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order circular instruction buffer that issues its head once source registers are free
module issue_queue
    import issue_queue_pkg::*;
(
    input logic           clk,
    input logic           reset,
    issue_queue_if.slave  iq
);
    iq_entry_t        mem_q [DEPTH];
    iq_entry_t        head;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             enq, deq, rj_busy, rkd_busy;
    // handshakes, outputs and next pointer state; allowin looks only at registered occupancy
    always_comb begin
        head              = mem_q[head_q];
        iq.IQ_allowin     = count_q != FULL_CNT;
        iq.iq_to_is_valid = (count_q != '0) && !(rj_busy || rkd_busy) && !iq.ds_flush;
        iq.iq_to_is_bus   = (count_q != '0) ? head.bus : '0;
        iq.iq_count       = count_q;
        enq               = iq.ds_to_is_valid && iq.IQ_allowin && !iq.ds_flush;
        deq               = iq.iq_to_is_valid && iq.is_allowin;
        head_d            = iq.ds_flush ? '0 : head_q + PTR_W'(deq);
        tail_d            = iq.ds_flush ? '0 : tail_q + PTR_W'(enq);
        count_d           = iq.ds_flush ? '0 : count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
        vld_d             = iq.ds_flush ? '0 : (vld_q & ~(DEPTH'(deq) << head_q)) | (DEPTH'(enq) << tail_q);
    end
    // pointer, occupancy and entry-valid registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end
    // entry payload storage, written at the tail on enqueue
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= '{bus: iq.ds_to_is_bus, rj: iq.ds_rj, rkd: iq.ds_rkd, dest: iq.ds_dest, gr_we: iq.ds_gr_we};
    end
    iq_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .sb_clear_i (iq.sb_clear),
        .set_en_i   (deq && head.gr_we && head.dest != 5'd0),
        .set_reg_i  (head.dest),
        .wb_valid_i (iq.wb_valid),
        .wb_dest_i  (iq.wb_dest),
        .rd0_reg_i  (head.rj),
        .rd1_reg_i  (head.rkd),
        .rd0_busy_o (rj_busy),
        .rd1_busy_o (rkd_busy)
    );
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: scoreboard bench for the issue queue covering fill/drain, RAW stalls, r0, set/clear race, flush, sb_clear and async reset
module tb_issue_queue;
    import issue_queue_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [BUS_W-1:0] expq [$];
    issue_queue_if iqif();
    issue_queue dut (.clk(clk), .reset(reset), .iq(iqif.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic send(input logic [4:0] rj, input logic [4:0] rkd, input logic [4:0] dest, input logic we);
        logic [223:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        iqif.ds_to_is_bus   = r[BUS_W-1:0];
        iqif.ds_rj          = rj;
        iqif.ds_rkd         = rkd;
        iqif.ds_dest        = dest;
        iqif.ds_gr_we       = we;
        iqif.ds_to_is_valid = 1'b1;
    endtask

    task automatic idle;
        iqif.ds_to_is_valid = 1'b0;
    endtask

    // reference model: occupancy and head payload follow the queue of accepted instructions
    always @(negedge clk) begin
        int sz;
        if (reset) expq.delete();
        else begin
            sz = expq.size();
            check("count", iqif.iq_count, sz);
            check("allowin", iqif.IQ_allowin, sz != DEPTH);
            check("head_bus", iqif.iq_to_is_bus, sz != 0 ? expq[0] : '0);
            if (sz == 0) check("empty_valid", iqif.iq_to_is_valid, 0);
            if (iqif.iq_to_is_valid && iqif.is_allowin && sz != 0) void'(expq.pop_front());
            if (iqif.ds_flush) expq.delete();
            else if (iqif.ds_to_is_valid && sz != DEPTH) expq.push_back(iqif.ds_to_is_bus);
        end
    end

    initial begin
        iqif.ds_flush = 0; iqif.sb_clear = 0; iqif.ds_to_is_valid = 0; iqif.ds_to_is_bus = '0;
        iqif.ds_rj = 0; iqif.ds_rkd = 0; iqif.ds_dest = 0; iqif.ds_gr_we = 0;
        iqif.is_allowin = 0; iqif.wb_valid = 0; iqif.wb_dest = 0;
        mid;
        check("rst_allowin", iqif.IQ_allowin, 1);
        check("rst_valid", iqif.iq_to_is_valid, 0);
        check("rst_bus", iqif.iq_to_is_bus, 0);
        check("rst_count", iqif.iq_count, 0);
        tick;
        reset = 0;
        // fill past capacity, then drain in order
        for (int k = 0; k < 5; k++) begin send(0, 0, 1, 0); tick; end
        mid;
        check("fill_allowin", iqif.IQ_allowin, 0);
        check("fill_count", iqif.iq_count, 4);
        tick;
        iqif.is_allowin = 1;
        tick;
        tick;
        idle;
        repeat (3) tick;
        mid;
        check("drain_count", iqif.iq_count, 0);
        // RAW on r5 released by same-cycle writeback
        tick;
        send(1, 2, 5, 1); tick;
        send(5, 3, 6, 1); tick;
        idle;
        mid;
        check("raw_stall", iqif.iq_to_is_valid, 0);
        tick;
        mid;
        check("raw_stall2", iqif.iq_to_is_valid, 0);
        tick;
        iqif.wb_valid = 1; iqif.wb_dest = 5;
        mid;
        check("raw_wb_issue", iqif.iq_to_is_valid, 1);
        tick;
        iqif.wb_dest = 6;
        mid;
        check("raw_done_count", iqif.iq_count, 0);
        tick;
        iqif.wb_valid = 0;
        // writes to r0 never create a hazard
        send(1, 0, 0, 1); tick;
        send(0, 0, 7, 1); tick;
        idle;
        mid;
        check("r0_no_stall", iqif.iq_to_is_valid, 1);
        tick;
        iqif.wb_valid = 1; iqif.wb_dest = 7;
        tick;
        iqif.wb_valid = 0;
        // issuing writer of r9 while r9 writes back: busy stays set
        send(0, 0, 9, 1); tick;
        send(9, 0, 2, 0);
        iqif.wb_valid = 1; iqif.wb_dest = 9;
        tick;
        idle;
        iqif.wb_valid = 0;
        mid;
        check("setclr_busy", iqif.iq_to_is_valid, 0);
        tick;
        iqif.wb_valid = 1; iqif.wb_dest = 9;
        mid;
        check("setclr_release", iqif.iq_to_is_valid, 1);
        tick;
        iqif.wb_valid = 0;
        // flush with three queued and one pending; r11 busy survives
        send(0, 0, 11, 1); tick;
        idle; tick;
        iqif.is_allowin = 0;
        for (int k = 0; k < 3; k++) begin send(0, 0, 3, 0); tick; end
        send(0, 0, 3, 0);
        iqif.ds_flush = 1;
        iqif.is_allowin = 1;
        mid;
        check("flush_valid", iqif.iq_to_is_valid, 0);
        tick;
        iqif.ds_flush = 0;
        idle;
        mid;
        check("flush_count", iqif.iq_count, 0);
        tick;
        send(11, 0, 3, 0); tick;
        idle;
        mid;
        check("flush_busy_kept", iqif.iq_to_is_valid, 0);
        tick;
        iqif.wb_valid = 1; iqif.wb_dest = 11;
        mid;
        check("flush_wb_issue", iqif.iq_to_is_valid, 1);
        tick;
        iqif.wb_valid = 0;
        // sb_clear wipes a pending writer
        send(0, 0, 12, 1); tick;
        idle; tick;
        send(12, 0, 3, 0);
        iqif.sb_clear = 1;
        tick;
        iqif.sb_clear = 0;
        idle;
        mid;
        check("sbclr_no_stall", iqif.iq_to_is_valid, 1);
        tick;
        // asynchronous reset between edges
        send(0, 0, 4, 1); tick;
        idle; tick;
        iqif.is_allowin = 0;
        send(4, 0, 3, 0); tick;
        send(0, 0, 3, 0); tick;
        idle;
        mid;
        check("pre_rst_count", iqif.iq_count, 2);
        check("pre_rst_stall", iqif.iq_to_is_valid, 0);
        #2 reset = 1;
        #1;
        check("arst_count", iqif.iq_count, 0);
        check("arst_allowin", iqif.IQ_allowin, 1);
        check("arst_valid", iqif.iq_to_is_valid, 0);
        check("arst_bus", iqif.iq_to_is_bus, 0);
        repeat (2) tick;
        reset = 0;
        iqif.is_allowin = 1;
        send(4, 0, 3, 0); tick;
        idle;
        mid;
        check("post_rst_no_stall", iqif.iq_to_is_valid, 1);
        tick;
        mid;
        check("post_rst_count", iqif.iq_count, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- 4-entry in-order issue queue with register scoreboard, between ID_Stage and the issue/execute stage.
- Buffers decoded instructions and drives IQ_allowin back to ID.
- Releases the head instruction only when its source registers have no pending writer and the downstream stage accepts it.
- Tracks in-flight destination registers and clears them on writeback.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).
- BUS_W, 211, width of the decoded-instruction bus; equals `DS_TO_IS_BUS_WD in myCPU.vh.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ds_flush  in  1  pipeline flush (branch mispredict/exception); discards all queued entries
- sb_clear  in  1  clears the whole scoreboard; asserted only when the backend is empty
- ds_to_is_valid  in  1  ID has an instruction
- ds_to_is_bus  in  BUS_W  decoded instruction payload, stored opaque
- ds_rj  in  5  source register 1
- ds_rkd  in  5  source register 2 (0 means unused)
- ds_dest  in  5  destination register
- ds_gr_we  in  1  instruction writes the register file
- IQ_allowin  out  1  queue can accept this cycle
- is_allowin  in  1  downstream stage accepts this cycle
- iq_to_is_valid  out  1  head entry is issuable
- iq_to_is_bus  out  BUS_W  head payload
- wb_valid  in  1  writeback releases a destination register
- wb_dest  in  5  register released
- iq_count  out  PTR_W+1  occupancy

Behaviour:
- Reset, asynchronous: head and tail pointers = 0, count = 0, scoreboard busy[31:0] = 0, all entry valid bits = 0.
- Outputs after reset: IQ_allowin = 1, iq_to_is_valid = 0, iq_to_is_bus = 0, iq_count = 0.
- Storage: circular buffer. Each entry holds {bus, rj, rkd, dest, gr_we}. Pointers are PTR_W bits and wrap modulo DEPTH. count is kept separately.
- IQ_allowin = (count != DEPTH). It is registered-state only; a same-cycle dequeue does not open a slot.
- Enqueue when ds_to_is_valid && IQ_allowin && !ds_flush. The entry is written at the tail and tail increments.
- Hazard: hz = busy_eff[rj] || busy_eff[rkd].
  - busy_eff = busy & ~(wb_valid ? onehot(wb_dest) : 0).
  - A same-cycle writeback unblocks the waiter.
  - Register 0 is never busy.
- iq_to_is_valid = (count != 0) && !hz && !ds_flush. iq_to_is_bus = head payload when count != 0, else 0.
- Dequeue when iq_to_is_valid && is_allowin. Head increments. If gr_we && dest != 0, busy[dest] is set next cycle.
- Latency: an instruction enqueued in cycle N can issue in cycle N+1 at the earliest. There is no bypass from input to output.
- Scoreboard update priority, highest first:
  1. reset
  2. sb_clear (all bits 0)
  3. dequeue set
  4. wb clear
  If a set and a clear hit the same register in one cycle, the set wins.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- Full: no enqueue, even if a dequeue happens in the same cycle.
- Empty: iq_to_is_valid = 0 and no dequeue.
- ds_flush: next cycle head = tail = count = 0. There is no enqueue or dequeue in the flush cycle, and the scoreboard is not cleared by it.
- Killed in-flight instructions still assert wb_valid at writeback, so their busy bits drain.
- The hazard check stalls only the head. In-order issue: younger entries never bypass the head.
- Downstream must not drop a handshaked instruction.

Decomposition:
- Shared header myCPU.vh: `DS_TO_IS_BUS_WD, and `IQ_DEPTH as the DEPTH default.
- One sub-module, iq_scoreboard, is natural. It holds the 32-bit busy vector plus set/clear/clear-all logic. It exposes two combinational read ports that apply the same-cycle wb bypass.
- The FIFO and the issue logic stay in issue_queue.

Test Plan:
- Fill/drain: enqueue 5 instructions with is_allowin = 0 -> IQ_allowin drops after 4, iq_count = 4, the 5th is held in ID. Then raise is_allowin -> issue in order, one per cycle, and iq_count returns to 0.
- RAW stall: issue add r5 <- r1,r2, then sub r6 <- r5,r3 -> sub blocked (iq_to_is_valid = 0) until the wb_valid/wb_dest = 5 cycle, and issues in that same cycle.
- r0 write: addi r0 then or r7 <- r0,r0 -> no stall; busy stays 0.
- Same-cycle set and clear: dequeue of a writer of r9 while wb_dest = 9 -> busy[9] = 1 afterwards.
- Flush: queue holds 3 entries and an enqueue is pending; assert ds_flush -> iq_count = 0 next cycle, iq_to_is_valid = 0 during the flush cycle, pending instruction discarded, busy bits unchanged.
- Async reset mid-operation: assert reset between clock edges with count = 2 and busy[4] = 1 -> all outputs reach reset values immediately, without a clock edge.
